// File: rtl/eth_rx_arbiter.sv
// Frame-level round-robin arbiter: N_PORTS byte streams share one consumer, grant held per frame.
// Optional idle-timeout abort of a stalled granted port is enabled by defining ETH_ARB_TIMEOUT_EN.
module eth_rx_arbiter #(
  parameter int N_PORTS     = 2,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [8*N_PORTS-1:0]   in_byte,
  input  logic [N_PORTS-1:0]     in_valid,
  input  logic [N_PORTS-1:0]     in_last,
  output logic [N_PORTS-1:0]     in_ready,
  output logic [7:0]             out_byte,
  output logic                   out_valid,
  output logic                   out_last,
  output logic [1:0]             out_port,
  input  logic                   out_ready,
  output logic                   frame_done,
  output logic                   frame_abort,
  output logic [CNT_W-1:0]       frame_len
);

  typedef enum logic {IDLE, FWD} state_t;

  state_t           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic [1:0]       rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0] frame_len_q, frame_len_d;
  logic             frame_done_q, frame_done_d;

  logic [31:0]      byte_pad;
  logic [3:0]       valid_pad, last_pad;
  logic [7:0]       g_byte;
  logic             g_valid, g_last;
  logic [1:0]       pick, grant_nxt;
  logic [2:0]       scan_idx;
  logic [CNT_W-1:0] cnt_inc;

  // Pad to four ports so a 2-bit grant indexes every width exactly.
  assign byte_pad  = 32'(in_byte);
  assign valid_pad = 4'(in_valid);
  assign last_pad  = 4'(in_last);

  assign g_byte  = byte_pad[{grant_q, 3'b000} +: 8];
  assign g_valid = valid_pad[grant_q];
  assign g_last  = last_pad[grant_q];

  assign grant_nxt = (grant_q == 2'(N_PORTS - 1)) ? 2'd0 : grant_q + 2'd1;
  assign cnt_inc   = (&byte_cnt_q) ? byte_cnt_q : byte_cnt_q + CNT_W'(1);

  // Lowest offset from rr_ptr wins, so scan offsets downward and let later hits override.
  always_comb begin
    pick     = rr_ptr_q;
    scan_idx = '0;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      scan_idx = {1'b0, rr_ptr_q} + 3'(k);
      if (scan_idx >= 3'(N_PORTS)) begin
        scan_idx = scan_idx - 3'(N_PORTS);
      end
      if (valid_pad[scan_idx[1:0]]) begin
        pick = scan_idx[1:0];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_ready
      assign in_ready[gi] = (state_q == FWD) && (grant_q == 2'(gi)) && out_ready;
    end
  endgenerate

`ifdef ETH_ARB_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              frame_abort_q, frame_abort_d;
  assign frame_abort = frame_abort_q;
`else
  assign frame_abort = 1'b0;
  if (TIMEOUT_CYC < 1) begin : g_timeout_param_unused
  end
`endif

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    byte_cnt_d   = byte_cnt_q;
    frame_len_d  = frame_len_q;
    frame_done_d = 1'b0;
    out_byte     = 8'd0;
    out_valid    = 1'b0;
    out_last     = 1'b0;
`ifdef ETH_ARB_TIMEOUT_EN
    idle_d        = idle_q;
    frame_abort_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|in_valid) begin
          grant_d    = pick;
          byte_cnt_d = '0;
          state_d    = FWD;
`ifdef ETH_ARB_TIMEOUT_EN
          idle_d     = '0;
`endif
        end
      end
      FWD: begin
        out_byte  = g_byte;
        out_valid = g_valid;
        out_last  = g_last;
        if (g_valid && out_ready) begin
          byte_cnt_d = cnt_inc;
          if (g_last) begin
            frame_done_d = 1'b1;
            frame_len_d  = cnt_inc;
            rr_ptr_d     = grant_nxt;
            state_d      = IDLE;
          end
        end
`ifdef ETH_ARB_TIMEOUT_EN
        // Only source silence counts; downstream back-pressure never ages the grant.
        if (!g_valid) begin
          if (idle_q == IDLE_W'(TIMEOUT_CYC - 1)) begin
            frame_abort_d = 1'b1;
            frame_len_d   = byte_cnt_q;
            rr_ptr_d      = grant_nxt;
            state_d       = IDLE;
          end else begin
            idle_d = idle_q + IDLE_W'(1);
          end
        end else begin
          idle_d = '0;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= 2'd0;
      rr_ptr_q     <= 2'd0;
      byte_cnt_q   <= '0;
      frame_len_q  <= '0;
      frame_done_q <= 1'b0;
`ifdef ETH_ARB_TIMEOUT_EN
      idle_q        <= '0;
      frame_abort_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_ptr_q     <= rr_ptr_d;
      byte_cnt_q   <= byte_cnt_d;
      frame_len_q  <= frame_len_d;
      frame_done_q <= frame_done_d;
`ifdef ETH_ARB_TIMEOUT_EN
      idle_q        <= idle_d;
      frame_abort_q <= frame_abort_d;
`endif
    end
  end

  assign out_port   = grant_q;
  assign frame_done = frame_done_q;
  assign frame_len  = frame_len_q;

endmodule

// File: tb/tb_eth_rx_arbiter.sv
// Randomized bench for eth_rx_arbiter with a cycle-level behavioural model and frame scoreboard.
// Compile with ETH_ARB_TIMEOUT_EN defined to exercise the idle-timeout abort path.
module tb_eth_rx_arbiter;
  localparam int N   = 2;
  localparam int CW  = 16;
  localparam int TO  = 64;
  localparam int CMAX = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [8*N-1:0] in_byte;
  logic [N-1:0]   in_valid, in_last, in_ready;
  logic [7:0]     out_byte;
  logic           out_valid, out_last, out_ready;
  logic [1:0]     out_port;
  logic           frame_done, frame_abort;
  logic [CW-1:0]  frame_len;

  eth_rx_arbiter #(.N_PORTS(N), .CNT_W(CW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .in_byte(in_byte), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_byte(out_byte), .out_valid(out_valid), .out_last(out_last),
    .out_port(out_port), .out_ready(out_ready), .frame_done(frame_done),
    .frame_abort(frame_abort), .frame_len(frame_len)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: which port owns the consumer, fairness pointer, bytes counted so far.
  int m_grant, m_rr, m_port, m_cnt, m_len, m_idle;
  bit m_done, m_abort;

  // Sources
  int         p_len[N], p_idx[N], p_closed[N], frames_left[N], beats[N];
  bit         p_valid[N], p_last[N], p_inframe[N], acc[N];
  logic [7:0] p_byte[N];
  int         fixed_len, ready_mode;
  bit         bubble;
  int         done_ports[$];

  task automatic model_reset();
    m_grant = -1; m_rr = 0; m_port = 0; m_cnt = 0; m_len = 0; m_idle = 0;
    m_done = 0; m_abort = 0;
  endtask

  task automatic model_check();
    logic [N-1:0] er;
    logic [7:0]   eb;
    bit           ev, el, found;
    int           g;
    er = '0; eb = 8'd0; ev = 0; el = 0;
    if (m_grant >= 0) begin
      g  = m_grant;
      eb = in_byte[8*g +: 8];
      ev = in_valid[g];
      el = in_last[g];
      if (out_ready) er[g] = 1'b1;
    end
    check_val("out_valid", out_valid, ev);
    check_val("out_byte", out_byte, eb);
    check_val("out_last", out_last, el);
    check_val("out_port", out_port, m_port);
    check_val("in_ready", in_ready, er);
    check_val("frame_done", frame_done, m_done);
    check_val("frame_abort", frame_abort, m_abort);
    if (m_done || m_abort) check_val("frame_len", frame_len, m_len);
    if (m_done && frame_done === 1'b1) begin
      check_val("frame_len_vs_src", frame_len, p_closed[m_port]);
      $display("frame done  port=%0d len=%0d", m_port, frame_len);
      done_ports.push_back(m_port);
    end
    if (m_abort && frame_abort === 1'b1)
      $display("frame abort port=%0d len=%0d", m_port, frame_len);
    for (int p = 0; p < N; p++) begin
      acc[p] = er[p] && in_valid[p];
      if (acc[p]) beats[p]++;
    end
    // Advance the model to the state after this clock edge.
    if (!rst_n) begin
      model_reset();
    end else begin
      m_done = 0; m_abort = 0;
      if (m_grant < 0) begin
        if (|in_valid) begin
          found = 0;
          for (int k = 0; k < N; k++) begin
            if (!found && in_valid[(m_rr + k) % N]) begin
              m_grant = (m_rr + k) % N;
              found = 1;
            end
          end
          m_port = m_grant; m_cnt = 0; m_idle = 0;
        end
      end else begin
        g = m_grant;
        if (in_valid[g] && out_ready) begin
          if (m_cnt < CMAX) m_cnt++;
          if (in_last[g]) begin
            m_done = 1; m_len = m_cnt; m_rr = (g + 1) % N; m_grant = -1;
          end
        end
`ifdef ETH_ARB_TIMEOUT_EN
        if (m_grant >= 0) begin
          if (!in_valid[g]) begin
            m_idle++;
            if (m_idle == TO) begin
              m_abort = 1; m_len = m_cnt; m_rr = (g + 1) % N; m_grant = -1;
            end
          end else begin
            m_idle = 0;
          end
        end
`endif
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_sources();
    for (int p = 0; p < N; p++) begin
      in_byte[8*p +: 8] = p_byte[p];
      in_valid[p]       = p_valid[p];
      in_last[p]        = p_last[p];
    end
  endtask

  task automatic reset_sources();
    for (int p = 0; p < N; p++) begin
      p_inframe[p] = 0; p_valid[p] = 0; p_last[p] = 0; acc[p] = 0;
    end
    drive_sources();
  endtask

  task automatic update_sources();
    for (int p = 0; p < N; p++) begin
      if (acc[p]) begin
        if (p_last[p]) begin
          p_closed[p] = p_len[p]; p_inframe[p] = 0; p_valid[p] = 0; p_last[p] = 0;
        end else begin
          p_idx[p]++;
          p_byte[p]  = 8'($urandom);
          p_last[p]  = (p_idx[p] == p_len[p] - 1);
          p_valid[p] = bubble ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
      end else if (p_inframe[p] && !p_valid[p]) begin
        p_valid[p] = bubble ? 1'($urandom_range(0, 1)) : 1'b1;
      end else if (!p_inframe[p] && frames_left[p] > 0 && (!bubble || $urandom_range(0, 2) == 0)) begin
        p_len[p] = (fixed_len > 0) ? fixed_len :
                   (($urandom_range(0, 9) == 0) ? 46 : int'($urandom_range(1, 16)));
        p_idx[p] = 0; p_byte[p] = 8'($urandom); p_last[p] = (p_len[p] == 1);
        p_valid[p] = 1; p_inframe[p] = 1; frames_left[p]--;
      end
    end
    drive_sources();
    case (ready_mode)
      0:       out_ready = ($urandom_range(0, 3) != 0);
      2:       out_ready = ~out_ready;
      default: out_ready = 1'b1;
    endcase
  endtask

  task automatic run(input int n);
    repeat (n) begin
      update_sources();
      step();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_out_valid"}, out_valid, 0);
    check_val({tag, "_out_last"}, out_last, 0);
    check_val({tag, "_out_byte"}, out_byte, 0);
    check_val({tag, "_out_port"}, out_port, 0);
    check_val({tag, "_in_ready"}, in_ready, 0);
    check_val({tag, "_frame_done"}, frame_done, 0);
    check_val({tag, "_frame_abort"}, frame_abort, 0);
    check_val({tag, "_frame_len"}, frame_len, 0);
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    reset_sources();
    repeat (cycles) step();
    rst_n = 1'b1;
  endtask

  int exp_order[$];
  int waited, abort_at, abort_len, pulses;

  initial begin
    rst_n = 1'b0; in_byte = '0; in_valid = '0; in_last = '0; out_ready = 1'b1;
    for (int p = 0; p < N; p++) begin
      p_len[p] = 0; p_idx[p] = 0; p_closed[p] = 0; frames_left[p] = 0; beats[p] = 0;
      p_byte[p] = 8'd0;
    end
    reset_sources();
    model_reset();
    fixed_len = 0; ready_mode = 1; bubble = 0;
    @(posedge clk);
    #1;
    do_reset(2);
    check_reset_outputs("reset");

    // Single 46-byte frame on port 0
    frames_left[0] = 1; fixed_len = 46; done_ports.delete();
    beats[0] = 0;
    run(60);
    check_val("A_frames", done_ports.size(), 1);
    check_val("A_port", (done_ports.size() > 0) ? done_ports[0] : -1, 0);
    check_val("A_beats", beats[0], 46);

    // Simultaneous requests after reset: port 0 first, then port 1
    do_reset(1);
    frames_left[0] = 1; frames_left[1] = 1; fixed_len = 0; done_ports.delete();
    run(120);
    exp_order = '{0, 1};
    check_val("B_frames", done_ports.size(), 2);
    for (int i = 0; i < 2; i++)
      check_val("B_order", (done_ports.size() > i) ? done_ports[i] : -1, exp_order[i]);

    // Port 1 streaming, port 0 joins: grants alternate
    fixed_len = 8; done_ports.delete();
    frames_left[1] = 3;
    run(2);
    frames_left[0] = 2;
    run(100);
    exp_order = '{1, 0, 1, 0, 1};
    check_val("C_frames", done_ports.size(), 5);
    for (int i = 0; i < 5; i++)
      check_val("C_order", (done_ports.size() > i) ? done_ports[i] : -1, exp_order[i]);

    // Toggling out_ready during a 10-byte frame
    fixed_len = 10; ready_mode = 2; done_ports.delete(); beats[0] = 0;
    frames_left[0] = 1;
    run(40);
    check_val("D_beats", beats[0], 10);
    check_val("D_frames", done_ports.size(), 1);

    // Random traffic with a one-cycle reset in the middle of a frame
    fixed_len = 0; ready_mode = 0; bubble = 1;
    frames_left[0] = 1000; frames_left[1] = 1000;
    run(1500);
    waited = 0;
    while (!(m_grant >= 0 && m_cnt > 0) && waited < 300) begin
      run(1);
      waited++;
    end
    check_val("E_midframe_found", (waited < 300), 1);
    do_reset(1);
    check_reset_outputs("midreset");
    step();
    check_val("E_no_pulse_done", frame_done, 0);
    check_val("E_no_pulse_abort", frame_abort, 0);
    run(1500);

    // Drain all traffic
    frames_left[0] = 0; frames_left[1] = 0; bubble = 0; ready_mode = 1;
    waited = 0;
    while ((p_inframe[0] || p_inframe[1] || m_grant >= 0) && waited < 400) begin
      run(1);
      waited++;
    end
    check_val("drain_done", (waited < 400), 1);
    run(3);

    // Stalled granted port: 5 bytes from port 0, then silence while port 1 waits
    do_reset(1);
    out_ready = 1'b1;
    in_valid = '0; in_last = '0;
    in_valid[0] = 1'b1;
    beats[0] = 0; waited = 0;
    while (beats[0] < 5 && waited < 20) begin
      in_byte[7:0] = 8'(beats[0] + 8'h30);
      step();
      waited++;
    end
    check_val("F_beats", beats[0], 5);
    in_valid[0] = 1'b0;
    in_valid[1] = 1'b1;
    in_byte[15:8] = 8'hA5;
`ifdef ETH_ARB_TIMEOUT_EN
    abort_at = -1; abort_len = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (frame_abort === 1'b1 && abort_at < 0) begin
        abort_at = i; abort_len = frame_len;
      end
      model_check();
      @(posedge clk);
      #1;
    end
    check_val("F_abort_delay", abort_at, 65);
    check_val("F_abort_len", abort_len, 5);
    check_val("F_next_port", out_port, 1);
`else
    pulses = 0;
    repeat (1000) begin
      @(negedge clk);
      if (frame_abort === 1'b1 || frame_done === 1'b1) pulses++;
      model_check();
      @(posedge clk);
      #1;
    end
    check_val("F_held_pulses", pulses, 0);
    check_val("F_held_port", out_port, 0);
    check_val("F_held_ready", in_ready, 2'b01);
    in_valid[0] = 1'b1; in_last[0] = 1'b1; p_closed[0] = 6;
    step();
    in_valid[0] = 1'b0; in_last[0] = 1'b0;
    step();
    run(0);
    step();
    step();
    check_val("F_next_port", out_port, 1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
